i2c_target_core: RTL and testbench

Parametrised I2C target front end that replaces the bare bus sampler in the hasher top level. It synchronises and glitch-filters SCL/SDA, detects START, repeated START and STOP, matches a configurable 7-bit address, shifts write bytes out to the hashing datapath, and serialises read bytes back onto the bus with correct ACK/NACK handling. The open-drain SDA driver is exposed as a single output-enable bit for the top level to map onto `uio_oe`/`uio_out`.

---
 rtl/i2c_pkg.sv | 20 ++
 rtl/i2c_glitch_filter.sv | 50 +++++
 rtl/i2c_target_core.sv | 210 +++++++++++++++++++++
 tb/tb_i2c_target_core.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// Shared types and defaults for the I2C target front end.
// Used by the glitch filter and i2c_target_core.
package i2c_pkg;

   localparam int         BYTE_W               = 8;
   localparam logic [6:0] DEFAULT_ADDRESS      = 7'h42;
   localparam int         DEFAULT_FILTER_DEPTH = 3;

   typedef enum logic [2:0] {
      IDLE,
      ADDR,
      ADDR_ACK,
      WRITE,
      WRITE_ACK,
      READ,
      READ_ACK,
      IGNORE
   } i2c_state_t;

endpackage

// File: rtl/i2c_glitch_filter.sv
// Two-flop synchroniser plus a run-length filter on one bus line.
// The output follows the pin 2 + FILTER_DEPTH cycles later and resets to 1.
module i2c_glitch_filter #(
   parameter int FILTER_DEPTH = 3
) (
   input  logic clk,
   input  logic reset,
   input  logic pin_in,
   output logic filt_out
);

   localparam int CNT_W = $clog2(FILTER_DEPTH + 1);

   logic             sync1_q, sync1_d;
   logic             sync2_q, sync2_d;
   logic             filt_q, filt_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   // The counter runs only while the synchronised sample disagrees with the output.
   always_comb begin
      sync1_d = pin_in;
      sync2_d = sync1_q;
      filt_d  = filt_q;
      cnt_d   = '0;
      if (sync2_q != filt_q) begin
         if (cnt_q == CNT_W'(FILTER_DEPTH - 1)) begin
            filt_d = sync2_q;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
         filt_q  <= 1'b1;
         cnt_q   <= '0;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
         filt_q  <= filt_d;
         cnt_q   <= cnt_d;
      end
   end

   assign filt_out = filt_q;

endmodule

// File: rtl/i2c_target_core.sv
// I2C target front end: filtered START/STOP detection, address match, byte rx/tx, ACK/NACK.
// Event pulses lag the filtered edge by 1 cycle; I2C_GENERAL_CALL_EN also answers address byte 8'h00.
module i2c_target_core
   import i2c_pkg::*;
#(
   parameter logic [6:0] ADDRESS      = DEFAULT_ADDRESS,
   parameter int         FILTER_DEPTH = DEFAULT_FILTER_DEPTH
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              scl_in,
   input  logic              sda_in,
   output logic              sda_oe,
   output logic              seen_start,
   output logic              seen_repeated_start,
   output logic              seen_stop,
   output logic              addr_match,
   output logic              is_read,
   output logic [BYTE_W-1:0] rx_data,
   output logic              rx_valid,
   input  logic [BYTE_W-1:0] tx_data,
   output logic              tx_req,
   output logic              tx_nack
);

   logic scl_f, sda_f;

   i2c_glitch_filter #(.FILTER_DEPTH(FILTER_DEPTH)) u_scl_filter (
      .clk(clk), .reset(reset), .pin_in(scl_in), .filt_out(scl_f)
   );

   i2c_glitch_filter #(.FILTER_DEPTH(FILTER_DEPTH)) u_sda_filter (
      .clk(clk), .reset(reset), .pin_in(sda_in), .filt_out(sda_f)
   );

   i2c_state_t        state_q, state_d;
   logic [2:0]        bit_cnt_q, bit_cnt_d;
   logic [6:0]        shift_q, shift_d;
   logic [BYTE_W-1:0] tx_shift_q, tx_shift_d;
   logic [BYTE_W-1:0] rx_data_q, rx_data_d;
   logic              scl_prev_q, scl_prev_d, sda_prev_q, sda_prev_d;
   logic              sda_oe_q, sda_oe_d, is_read_q, is_read_d;
   logic              seen_start_q, seen_start_d, seen_rs_q, seen_rs_d;
   logic              seen_stop_q, seen_stop_d, addr_match_q, addr_match_d;
   logic              rx_valid_q, rx_valid_d, tx_nack_q, tx_nack_d;
   logic              tx_req_c;

   logic              scl_rise, scl_fall, start_det, stop_det, addr_ok, gen_call;
   logic [BYTE_W-1:0] rx_byte;

   assign scl_rise  = scl_f & ~scl_prev_q;
   assign scl_fall  = ~scl_f & scl_prev_q;
   assign start_det = scl_f & scl_prev_q & sda_prev_q & ~sda_f;
   assign stop_det  = scl_f & scl_prev_q & ~sda_prev_q & sda_f;
   assign rx_byte   = {shift_q, sda_f};

`ifdef I2C_GENERAL_CALL_EN
   assign gen_call = (rx_byte == 8'h00);
`else
   assign gen_call = 1'b0;
`endif

   assign addr_ok = (rx_byte[7:1] == ADDRESS) | gen_call;

   always_comb begin
      state_d      = state_q;
      bit_cnt_d    = bit_cnt_q;
      shift_d      = shift_q;
      tx_shift_d   = tx_shift_q;
      rx_data_d    = rx_data_q;
      sda_oe_d     = sda_oe_q;
      is_read_d    = is_read_q;
      scl_prev_d   = scl_f;
      sda_prev_d   = sda_f;
      seen_start_d = 1'b0;
      seen_rs_d    = 1'b0;
      seen_stop_d  = 1'b0;
      addr_match_d = 1'b0;
      rx_valid_d   = 1'b0;
      tx_nack_d    = 1'b0;
      tx_req_c     = 1'b0;

      if (start_det) begin
         state_d      = ADDR;
         bit_cnt_d    = '0;
         sda_oe_d     = 1'b0;
         is_read_d    = 1'b0;
         seen_start_d = (state_q == IDLE);
         seen_rs_d    = (state_q != IDLE);
      end else if (stop_det) begin
         state_d     = IDLE;
         bit_cnt_d   = '0;
         sda_oe_d    = 1'b0;
         is_read_d   = 1'b0;
         seen_stop_d = 1'b1;
      end else begin
         case (state_q)
            ADDR, WRITE: begin
               if (scl_rise) begin
                  shift_d   = rx_byte[6:0];
                  bit_cnt_d = bit_cnt_q + 3'd1;
                  if (bit_cnt_q == 3'd7) begin
                     if (state_q == WRITE) begin
                        rx_data_d  = rx_byte;
                        rx_valid_d = 1'b1;
                        state_d    = WRITE_ACK;
                     end else if (addr_ok) begin
                        addr_match_d = 1'b1;
                        is_read_d    = rx_byte[0];
                        state_d      = ADDR_ACK;
                     end else begin
                        state_d = IGNORE;
                     end
                  end
               end
            end
            // First falling edge opens the ACK slot, the second closes it.
            ADDR_ACK, WRITE_ACK: begin
               if (scl_fall) begin
                  if (!sda_oe_q) begin
                     sda_oe_d = 1'b1;
                  end else if (state_q == ADDR_ACK && is_read_q) begin
                     tx_req_c = 1'b1;
                  end else begin
                     sda_oe_d = 1'b0;
                     state_d  = WRITE;
                  end
               end
            end
            READ: begin
               if (scl_fall) begin
                  bit_cnt_d = bit_cnt_q + 3'd1;
                  if (bit_cnt_q == 3'd7) begin
                     sda_oe_d = 1'b0;
                     state_d  = READ_ACK;
                  end else begin
                     tx_shift_d = {tx_shift_q[6:0], 1'b0};
                     sda_oe_d   = ~tx_shift_q[6];
                  end
               end
            end
            READ_ACK: begin
               if (scl_rise && sda_f) begin
                  tx_nack_d = 1'b1;
                  state_d   = IGNORE;
               end else if (scl_fall) begin
                  tx_req_c = 1'b1;
               end
            end
            default: ;
         endcase

         // tx_data is taken in the same cycle tx_req is raised so bit 7 meets the 1-cycle drive slot.
         if (tx_req_c) begin
            tx_shift_d = tx_data;
            sda_oe_d   = ~tx_data[7];
            bit_cnt_d  = '0;
            state_d    = READ;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         bit_cnt_q    <= '0;
         shift_q      <= '0;
         tx_shift_q   <= '0;
         rx_data_q    <= '0;
         sda_oe_q     <= 1'b0;
         is_read_q    <= 1'b0;
         scl_prev_q   <= 1'b1;
         sda_prev_q   <= 1'b1;
         seen_start_q <= 1'b0;
         seen_rs_q    <= 1'b0;
         seen_stop_q  <= 1'b0;
         addr_match_q <= 1'b0;
         rx_valid_q   <= 1'b0;
         tx_nack_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         bit_cnt_q    <= bit_cnt_d;
         shift_q      <= shift_d;
         tx_shift_q   <= tx_shift_d;
         rx_data_q    <= rx_data_d;
         sda_oe_q     <= sda_oe_d;
         is_read_q    <= is_read_d;
         scl_prev_q   <= scl_prev_d;
         sda_prev_q   <= sda_prev_d;
         seen_start_q <= seen_start_d;
         seen_rs_q    <= seen_rs_d;
         seen_stop_q  <= seen_stop_d;
         addr_match_q <= addr_match_d;
         rx_valid_q   <= rx_valid_d;
         tx_nack_q    <= tx_nack_d;
      end
   end

   assign sda_oe              = sda_oe_q;
   assign seen_start          = seen_start_q;
   assign seen_repeated_start = seen_rs_q;
   assign seen_stop           = seen_stop_q;
   assign addr_match          = addr_match_q;
   assign is_read             = is_read_q;
   assign rx_data             = rx_data_q;
   assign rx_valid            = rx_valid_q;
   assign tx_req              = tx_req_c;
   assign tx_nack             = tx_nack_q;

endmodule

// File: tb/tb_i2c_target_core.sv
// Bench for i2c_target_core: a bit-banged I2C controller against a transaction-level reference model.
`timescale 1ns/1ps
module tb_i2c_target_core;

   localparam int         Q    = 12;
   localparam logic [6:0] ADDR = 7'h42;
`ifdef I2C_GENERAL_CALL_EN
   localparam bit GC_EN = 1'b1;
`else
   localparam bit GC_EN = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       reset, scl_in, sda_drv, sda_in;
   logic       sda_oe, seen_start, seen_repeated_start, seen_stop, addr_match;
   logic       is_read, rx_valid, tx_req, tx_nack;
   logic [7:0] rx_data, tx_data;

   assign sda_in = sda_drv & ~sda_oe;

   always #5 clk = ~clk;

   i2c_target_core #(.ADDRESS(ADDR), .FILTER_DEPTH(3)) dut (
      .clk(clk), .reset(reset), .scl_in(scl_in), .sda_in(sda_in), .sda_oe(sda_oe),
      .seen_start(seen_start), .seen_repeated_start(seen_repeated_start),
      .seen_stop(seen_stop), .addr_match(addr_match), .is_read(is_read),
      .rx_data(rx_data), .rx_valid(rx_valid), .tx_data(tx_data),
      .tx_req(tx_req), .tx_nack(tx_nack)
   );

   int total = 0;
   int bad   = 0;

   int n_start, n_rs, n_stop, n_match, n_txreq, n_nack, n_oe_hi, n_oe_viol;
   logic [7:0] rx_q[$];
   logic       oe_prev = 1'b0;

   always @(negedge clk) begin
      if (!reset) begin
         if (seen_start)          n_start++;
         if (seen_repeated_start) n_rs++;
         if (seen_stop)           n_stop++;
         if (addr_match)          n_match++;
         if (tx_req)              n_txreq++;
         if (tx_nack)             n_nack++;
         if (sda_oe)              n_oe_hi++;
         if (rx_valid)            rx_q.push_back(rx_data);
         if (sda_oe !== oe_prev && scl_in) n_oe_viol++;
      end
      oe_prev = sda_oe;
   end

   initial begin
      #900us;
      $display("FAIL watchdog simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   function automatic bit model_ack(input logic [7:0] a);
      return (a[7:1] == ADDR) || (GC_EN && a == 8'h00);
   endfunction

   task automatic clr_mon();
      n_start = 0; n_rs = 0; n_stop = 0; n_match = 0;
      n_txreq = 0; n_nack = 0; n_oe_hi = 0; n_oe_viol = 0;
      rx_q.delete();
   endtask

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic bus_start();
      sda_drv = 1'b1; wait_clk(Q);
      scl_in  = 1'b1; wait_clk(Q);
      sda_drv = 1'b0; wait_clk(Q);
      scl_in  = 1'b0; wait_clk(Q);
   endtask

   task automatic bus_stop();
      sda_drv = 1'b0; wait_clk(Q);
      scl_in  = 1'b1; wait_clk(Q);
      sda_drv = 1'b1; wait_clk(Q);
   endtask

   // One SCL period; optional 2-cycle SCL glitch inside the low phase.
   task automatic bus_bit(input logic b, input bit glitch, output logic s);
      sda_drv = b;
      if (glitch) begin
         wait_clk(4); scl_in = 1'b1; wait_clk(2); scl_in = 1'b0; wait_clk(Q - 6);
      end else begin
         wait_clk(Q);
      end
      scl_in = 1'b1; wait_clk(Q);
      s = sda_in;    wait_clk(Q);
      scl_in = 1'b0; wait_clk(Q);
   endtask

   task automatic write_byte(input logic [7:0] b, input int glitch_bit, output bit acked);
      logic s;
      for (int i = 7; i >= 0; i--) bus_bit(b[i], (i == glitch_bit), s);
      bus_bit(1'b1, 1'b0, s);
      acked = (s == 1'b0);
   endtask

   task automatic read_byte(input bit ack, input logic [7:0] next_tx, output logic [7:0] d);
      logic s;
      for (int i = 7; i >= 0; i--) begin
         bus_bit(1'b1, 1'b0, s);
         d[i] = s;
      end
      tx_data = next_tx;
      bus_bit(~ack, 1'b0, s);
   endtask

   task automatic test_reset();
      reset = 1'b1; scl_in = 1'b1; sda_drv = 1'b1; tx_data = 8'h00;
      wait_clk(5);
      reset = 1'b0;
      clr_mon();
      wait_clk(10);
      total++; if (sda_oe !== 1'b0) begin bad++; $display("FAIL rst_sda_oe got=%b exp=0", sda_oe); end
      total++; if (is_read !== 1'b0) begin bad++; $display("FAIL rst_is_read got=%b exp=0", is_read); end
      total++; if (rx_data !== 8'h00) begin bad++; $display("FAIL rst_rx_data got=%h exp=00", rx_data); end
      total++; if ({seen_start, seen_repeated_start, seen_stop, addr_match, rx_valid, tx_req, tx_nack} !== 7'b0) begin
         bad++; $display("FAIL rst_pulses got=%b exp=0000000",
                         {seen_start, seen_repeated_start, seen_stop, addr_match, rx_valid, tx_req, tx_nack});
      end
      total++; if (n_start + n_stop + n_rs !== 0) begin bad++; $display("FAIL rst_events got=%0d exp=0", n_start + n_stop + n_rs); end
   endtask

   task automatic test_write();
      bit a0, a1;
      clr_mon();
      bus_start();
      write_byte(8'h84, -1, a0);
      write_byte(8'hA5, -1, a1);
      bus_stop();
      wait_clk(10);
      total++; if (a0 !== 1'b1) begin bad++; $display("FAIL wr_addr_ack got=%b exp=1", a0); end
      total++; if (a1 !== 1'b1) begin bad++; $display("FAIL wr_data_ack got=%b exp=1", a1); end
      total++; if (n_match !== 1) begin bad++; $display("FAIL wr_addr_match got=%0d exp=1", n_match); end
      total++; if (rx_q.size() !== 1) begin bad++; $display("FAIL wr_rx_count got=%0d exp=1", rx_q.size()); end
      else begin
         total++; if (rx_q[0] !== 8'hA5) begin bad++; $display("FAIL wr_rx_byte got=%h exp=a5", rx_q[0]); end
      end
      total++; if (rx_data !== 8'hA5) begin bad++; $display("FAIL wr_rx_held got=%h exp=a5", rx_data); end
      total++; if (n_start !== 1 || n_stop !== 1 || n_rs !== 0) begin
         bad++; $display("FAIL wr_events got=%0d/%0d/%0d exp=1/1/0", n_start, n_stop, n_rs);
      end
      total++; if (sda_oe !== 1'b0) begin bad++; $display("FAIL wr_release got=%b exp=0", sda_oe); end
      total++; if (n_oe_viol !== 0) begin bad++; $display("FAIL wr_oe_scl_high got=%0d exp=0", n_oe_viol); end
   endtask

   task automatic test_read();
      bit a0;
      logic [7:0] d0, d1;
      clr_mon();
      tx_data = 8'h3C;
      bus_start();
      write_byte(8'h85, -1, a0);
      read_byte(1'b1, 8'hC3, d0);
      read_byte(1'b0, 8'h00, d1);
      total++; if (is_read !== 1'b1) begin bad++; $display("FAIL rd_is_read got=%b exp=1", is_read); end
      bus_stop();
      wait_clk(10);
      total++; if (a0 !== 1'b1) begin bad++; $display("FAIL rd_addr_ack got=%b exp=1", a0); end
      total++; if (d0 !== 8'h3C) begin bad++; $display("FAIL rd_byte0 got=%h exp=3c", d0); end
      total++; if (d1 !== 8'hC3) begin bad++; $display("FAIL rd_byte1 got=%h exp=c3", d1); end
      total++; if (n_txreq !== 2) begin bad++; $display("FAIL rd_tx_req got=%0d exp=2", n_txreq); end
      total++; if (n_nack !== 1) begin bad++; $display("FAIL rd_tx_nack got=%0d exp=1", n_nack); end
      total++; if (sda_oe !== 1'b0) begin bad++; $display("FAIL rd_release got=%b exp=0", sda_oe); end
      total++; if (is_read !== 1'b0) begin bad++; $display("FAIL rd_is_read_clr got=%b exp=0", is_read); end
      total++; if (n_oe_viol !== 0) begin bad++; $display("FAIL rd_oe_scl_high got=%0d exp=0", n_oe_viol); end
   endtask

   task automatic test_repeated_start();
      bit a0, a1, a2;
      logic [7:0] wb, tb_byte, d;
      wb = 8'($urandom);
      tb_byte = 8'($urandom);
      clr_mon();
      tx_data = tb_byte;
      bus_start();
      write_byte(8'h84, -1, a0);
      write_byte(wb, -1, a1);
      total++; if (is_read !== 1'b0) begin bad++; $display("FAIL rs_is_read_w got=%b exp=0", is_read); end
      bus_start();
      write_byte(8'h85, -1, a2);
      total++; if (is_read !== 1'b1) begin bad++; $display("FAIL rs_is_read_r got=%b exp=1", is_read); end
      read_byte(1'b0, 8'h00, d);
      bus_stop();
      wait_clk(10);
      total++; if ({a0, a1, a2} !== 3'b111) begin bad++; $display("FAIL rs_acks got=%b exp=111", {a0, a1, a2}); end
      total++; if (n_rs !== 1 || n_start !== 1) begin bad++; $display("FAIL rs_events got=%0d/%0d exp=1/1", n_rs, n_start); end
      total++; if (rx_q.size() !== 1 || rx_q[0] !== wb) begin bad++; $display("FAIL rs_rx got_n=%0d exp=%h", rx_q.size(), wb); end
      total++; if (d !== tb_byte) begin bad++; $display("FAIL rs_read got=%h exp=%h", d, tb_byte); end
      total++; if (n_match !== 2) begin bad++; $display("FAIL rs_match got=%0d exp=2", n_match); end
   endtask

   task automatic test_wrong_addr();
      bit a0, a1, a2;
      logic [6:0] a7;
      logic [7:0] abyte;
      do a7 = 7'($urandom_range(1, 127)); while (a7 == ADDR);
      abyte = {a7, 1'($urandom_range(0, 1))};
      clr_mon();
      bus_start();
      write_byte(abyte, -1, a0);
      write_byte(8'($urandom), -1, a1);
      write_byte(8'($urandom), -1, a2);
      bus_stop();
      wait_clk(10);
      total++; if ({a0, a1, a2} !== 3'b000) begin bad++; $display("FAIL wa_acks addr=%h got=%b exp=000", abyte, {a0, a1, a2}); end
      total++; if (n_oe_hi !== 0) begin bad++; $display("FAIL wa_oe_cycles got=%0d exp=0", n_oe_hi); end
      total++; if (rx_q.size() !== 0) begin bad++; $display("FAIL wa_rx got=%0d exp=0", rx_q.size()); end
      total++; if (n_match !== 0) begin bad++; $display("FAIL wa_match got=%0d exp=0", n_match); end
      total++; if (n_stop !== 1) begin bad++; $display("FAIL wa_stop got=%0d exp=1", n_stop); end
   endtask

   task automatic test_glitch();
      bit a0, a1;
      logic [7:0] b;
      b = 8'($urandom);
      clr_mon();
      bus_start();
      write_byte(8'h84, 6, a0);
      write_byte(b, 4, a1);
      bus_stop();
      wait_clk(10);
      total++; if ({a0, a1} !== 2'b11) begin bad++; $display("FAIL gl_acks got=%b exp=11", {a0, a1}); end
      total++; if (rx_q.size() !== 1 || rx_q[0] !== b) begin bad++; $display("FAIL gl_rx got_n=%0d exp=%h", rx_q.size(), b); end
   endtask

   task automatic test_general_call();
      bit a0, a1;
      logic [7:0] b;
      bit exp;
      b = 8'($urandom);
      exp = model_ack(8'h00);
      clr_mon();
      bus_start();
      write_byte(8'h00, -1, a0);
      write_byte(b, -1, a1);
      total++; if (is_read !== 1'b0) begin bad++; $display("FAIL gc_is_read got=%b exp=0", is_read); end
      bus_stop();
      wait_clk(10);
      total++; if (a0 !== exp) begin bad++; $display("FAIL gc_addr_ack got=%b exp=%b", a0, exp); end
      total++; if (a1 !== exp) begin bad++; $display("FAIL gc_data_ack got=%b exp=%b", a1, exp); end
      total++; if (n_match !== int'(exp)) begin bad++; $display("FAIL gc_match got=%0d exp=%0d", n_match, exp); end
      total++; if (rx_q.size() !== int'(exp)) begin bad++; $display("FAIL gc_rx got=%0d exp=%0d", rx_q.size(), exp); end
   endtask

   task automatic test_reset_mid_ack();
      logic s;
      bit a0;
      clr_mon();
      bus_start();
      for (int i = 7; i >= 0; i--) bus_bit(1'(8'h84 >> i), 1'b0, s);
      sda_drv = 1'b1; wait_clk(Q);
      scl_in = 1'b1; wait_clk(2);
      total++; if (sda_oe !== 1'b1) begin bad++; $display("FAIL rm_acking got=%b exp=1", sda_oe); end
      reset = 1'b1;
      @(posedge clk); #1;
      total++; if (sda_oe !== 1'b0) begin bad++; $display("FAIL rm_release got=%b exp=0", sda_oe); end
      wait_clk(3);
      reset = 1'b0;
      wait_clk(Q);
      scl_in = 1'b0; wait_clk(Q);
      bus_stop();
      wait_clk(10);
      clr_mon();
      bus_start();
      write_byte(8'h84, -1, a0);
      bus_stop();
      wait_clk(10);
      total++; if (a0 !== 1'b1 || n_start !== 1) begin bad++; $display("FAIL rm_recover got=%b/%0d exp=1/1", a0, n_start); end
   endtask

   task automatic test_back_to_back();
      for (int t = 0; t < 6; t++) begin
         logic [6:0] a7;
         logic       rw;
         logic [7:0] abyte, d;
         logic [7:0] bytes[4];
         logic [7:0] exp_rx[$];
         bit         ack, exp_ack, all_ok;
         int         n, exp_req;
         a7 = ($urandom_range(0, 1) != 0) ? ADDR : 7'($urandom_range(0, 127));
         rw = 1'($urandom_range(0, 1));
         abyte = {a7, rw};
         exp_ack = model_ack(abyte);
         n = $urandom_range(1, 3);
         for (int j = 0; j < 4; j++) bytes[j] = 8'($urandom);
         exp_rx.delete();
         exp_req = 0;
         all_ok = 1'b1;
         clr_mon();
         tx_data = bytes[0];
         bus_start();
         write_byte(abyte, -1, ack);
         total++; if (ack !== exp_ack) begin bad++; $display("FAIL bb_addr_ack t=%0d addr=%h got=%b exp=%b", t, abyte, ack, exp_ack); end
         if (exp_ack && rw) begin
            exp_req = n;
            for (int j = 0; j < n; j++) begin
               read_byte(j < n - 1, bytes[j + 1], d);
               if (d !== bytes[j]) all_ok = 1'b0;
            end
         end else begin
            for (int j = 0; j < n; j++) begin
               write_byte(bytes[j], -1, ack);
               if (ack !== exp_ack) all_ok = 1'b0;
               if (exp_ack) exp_rx.push_back(bytes[j]);
            end
         end
         bus_stop();
         wait_clk(10);
         total++; if (all_ok !== 1'b1) begin bad++; $display("FAIL bb_data t=%0d addr=%h got=%b exp=1", t, abyte, all_ok); end
         total++; if (rx_q !== exp_rx) begin bad++; $display("FAIL bb_rx t=%0d got_n=%0d exp_n=%0d", t, rx_q.size(), exp_rx.size()); end
         total++; if (n_txreq !== exp_req) begin bad++; $display("FAIL bb_tx_req t=%0d got=%0d exp=%0d", t, n_txreq, exp_req); end
         total++; if (n_match !== int'(exp_ack)) begin bad++; $display("FAIL bb_match t=%0d got=%0d exp=%0d", t, n_match, exp_ack); end
         total++; if (sda_oe !== 1'b0 || n_oe_viol !== 0) begin bad++; $display("FAIL bb_oe t=%0d got=%b/%0d exp=0/0", t, sda_oe, n_oe_viol); end
      end
   endtask

   initial begin
      test_reset();
      test_write();
      test_read();
      test_repeated_start();
      test_wrong_addr();
      test_glitch();
      test_general_call();
      test_reset_mid_ack();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
